pc_fetch_unit: RTL
==================

# pc_fetch_unit

Sequential fetch front end that owns the program-counter register and supplies the instruction fields consumed by the combinational next-PC logic. It issues word reads to instruction memory over a request/response handshake and holds the returned instruction for the decode stage. On handoff it loads the externally computed `pc_next`, closing the PC → fetch → next-PC → PC loop for the multi-cycle CPU.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `pc_cur`  out  32  current PC; feeds next-PC logic.
- `pc_next`  in  32  next PC from next-PC logic; sampled only on instruction handoff.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address; equals `pc_cur`.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  held instruction valid for decode.
- `instr_ready`  in  1  decode consumes the instruction this cycle.
- `instr`  out  32  held instruction word.
- `op`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `branch_delta`  out  16  `instr[15:0]`.
- `jump_target`  out  26  `instr[25:0]`.
- `fetch_err`  out  1  misaligned-PC error; present only with FETCH_ALIGN_CHECK_EN, otherwise tied 0.

## Operation
- FSM states: S_REQ, S_WAIT, S_HOLD, S_ERR. S_ERR exists only with FETCH_ALIGN_CHECK_EN.
- S_REQ:
  - `imem_req`=1, `imem_addr`=`pc_cur`.
  - `imem_ready`=1 → S_WAIT; otherwise stay, holding the address stable.
- S_WAIT:
  - `imem_req`=0.
  - `imem_rvalid`=1 → register `imem_rdata` into `instr`, go to S_HOLD.
  - `imem_rvalid` is ignored in every other state.
- S_HOLD:
  - `instr_valid`=1; `instr` and the field outputs stay stable.
  - `instr_ready`=1 → `pc_cur` <= `pc_next`, go to S_REQ.
  - `instr_ready`=0 → stay.
- Field outputs are combinational slices of the `instr` register and are valid only while `instr_valid`=1.
- `pc_cur` changes only on reset or on handoff (S_HOLD ∧ `instr_ready`). It is never incremented internally; all sequencing, including +4, comes from `pc_next`.
- `pc_next` may change freely outside the handoff cycle.

## Timing
- Reset values:
  - `pc_cur`=`RESET_PC`; state=S_REQ; `instr`=0; `instr_valid`=0; `fetch_err`=0.
  - `imem_req`=0 while `rst`=1, and 1 on the first cycle after `rst` falls.
- `rst` asserted in any state, including mid-fetch, returns to S_REQ with reset values on the next edge.
  - A memory response arriving after a mid-fetch reset lands in S_REQ and is discarded.
- Minimum cycles per instruction is 3, with `imem_ready`, `imem_rvalid` and `instr_ready` all immediate:
  - cycle 0: S_REQ, request accepted;
  - cycle 1: S_WAIT, data captured;
  - cycle 2: S_HOLD, handoff;
  - cycle 3: next request issued with the new PC.
- Memory contract: `imem_rvalid` arrives at least one cycle after the accepting `imem_ready`. At most one request is outstanding.
- `instr_valid` rises the cycle after capture and falls the cycle after handoff.
- A `pc_next` equal to `pc_cur` (self-loop) is legal and refetches the same address.

## Configuration
- Macro: `FETCH_ALIGN_CHECK_EN`.
- Defined: at handoff, if `pc_next[1:0]`≠2'b00:
  - load `pc_cur`=`pc_next` unmodified;
  - enter S_ERR and set `fetch_err`=1.
  - In S_ERR, `imem_req`=0 and `instr_valid`=0.
  - S_ERR and `fetch_err` are sticky until `rst`.
- Not defined: `pc_cur` loads `{pc_next[31:2],2'b00}` with the low bits silently cleared. S_ERR is absent and `fetch_err` is constant 0.

## Test plan
- Reset release, RESET_PC=0, all handshakes immediate:
  - `imem_addr` sequence is 0x0, 0x4, 0x8 with `pc_next`=`pc_cur`+4;
  - `instr_valid` pulses every 3rd cycle.
- Memory stalls: `imem_ready` low 2 cycles, then `imem_rvalid` delayed 3 cycles:
  - `imem_addr` holds 0x4 throughout;
  - `instr` = `imem_rdata` (0x1085_0003) exactly at capture;
  - `op`=6'h04, `branch_delta`=16'h0003.
- Decode backpressure: `instr_ready` low 4 cycles in S_HOLD while `pc_next` toggles:
  - `instr` and `pc_cur` remain stable;
  - `pc_cur` takes the `pc_next` value present in the `instr_ready`=1 cycle (0x0000_0040).
- Jump handoff: `instr`=0x0800_0010, `pc_next`=0x0000_0040:
  - `jump_target`=26'h10;
  - next `imem_addr`=0x40.
- Mid-fetch reset: `rst` in S_WAIT, then stale `imem_rvalid` one cycle after release:
  - `pc_cur`=RESET_PC, data ignored, `instr_valid` stays 0, fresh request issued.
- Misaligned `pc_next`=0x0000_0042:
  - with FETCH_ALIGN_CHECK_EN: `fetch_err`=1, `imem_req`=0 until `rst`;
  - without it: next `imem_addr`=0x40.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter owner and instruction fetch front end.
// Issues one word read at a time, holds the returned instruction for decode
// and loads the externally computed pc_next when decode takes the instruction.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned pc_next traps into
// a sticky error state instead of being silently word-aligned).
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_cur,
    input  logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [15:0] branch_delta,
    output logic [25:0] jump_target,
    output logic        fetch_err
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {StReq, StWait, StHold, StErr} state_e;
`else
    typedef enum logic [1:0] {StReq, StWait, StHold} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        err_q, err_d;
`else
    // Low PC bits are dropped on load when the alignment check is off.
    logic        unused_pc_next_low;
    assign unused_pc_next_low = ^pc_next[1:0];
`endif

    // Next-state, PC and instruction-register update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            StReq: begin
                if (imem_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (instr_ready) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    pc_d = pc_next;
                    if (pc_next[1:0] != 2'b00) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
`else
                    pc_d    = {pc_next[31:2], 2'b00};
                    state_d = StReq;
`endif
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            StErr: begin
                // Sticky until reset.
                state_d = StErr;
            end
`endif
            default: begin
                state_d = StReq;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StReq;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef FETCH_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Request is masked during reset so memory never sees a fetch from stale state.
    assign imem_req     = (state_q == StReq) && !rst;
    assign imem_addr    = pc_q;
    assign pc_cur       = pc_q;
    assign instr_valid  = (state_q == StHold);
    assign instr        = instr_q;
    assign op           = instr_q[31:26];
    assign funct        = instr_q[5:0];
    assign branch_delta = instr_q[15:0];
    assign jump_target  = instr_q[25:0];

`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule
